// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: clear control, two write ports, NRD read ports.
// Latency: reads combinational; writes and clear take effect on the clk edge.
// Backpressure: ready=0 while clearing; writes presented then are dropped.
//
// Signals: clr_req, ready, we0/wa0/wd0, we1/wa1/wd1 (priority port),
//          ra (NRD packed addresses), rd (NRD packed data), wr_conflict.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic                clr_req;
  logic                ready;
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [XLEN-1:0]     wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd1;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic                wr_conflict;

  modport master (
    output clr_req, we0, wa0, wd0, we1, wa1, wd1, ra,
    input  ready, rd, wr_conflict
  );

  modport slave (
    input  clr_req, we0, wa0, wd0, we1, wa1, wd1, ra,
    output ready, rd, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD async read ports, two prioritised write ports.
// Latency: reads 0 cycles (optional write bypass); writes land on the clk edge.
// Backpressure: ready=0 during the NREG-edge sequential clear; writes dropped.
//
// Ports: clk, rst (async active-low), bus (regfile_mp_if.slave):
//   clr_req -> start a sequential clear (sampled only while ready=1)
//   we/wa/wd 0,1 -> write ports, port 1 wins on same-address writes
//   ra/rd -> packed read addresses/data, port k at [k*AW]/[k*XLEN]
//   wr_conflict -> registered pulse after an edge where both ports hit one address
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   idx;
  logic            ready;
  logic            clear_en;
  logic            commit_en;
  logic            w0_ok;
  logic            w1_ok;
  logic            conflict_q;
  logic [XLEN-1:0] mem [NREG];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_CLEAR;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (idx == AW'(NREG - 1)) state_nxt = ST_READY;
      ST_READY: if (bus.clr_req)          state_nxt = ST_CLEAR;
      default:                            state_nxt = ST_CLEAR;
    endcase
  end

  // Outputs decoded from state only, so ready has no path from any input.
  // clear_en is also gated by rst so a held reset never writes storage.
  always_comb begin
    ready    = (state == ST_READY);
    clear_en = (state == ST_CLEAR) && rst;
  end

  // Clear index; NREG is a power of two so idx wraps to 0 on the last clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          idx <= '0;
    else if (clear_en) idx <= idx + 1'b1;
    else               idx <= '0;
  end

  // A write commits only in READY with no clear request, and never to a
  // hardwired-zero register. Bypass and conflict use the same qualifiers.
  assign commit_en = ready && !bus.clr_req;
  assign w0_ok = commit_en && bus.we0 && !((ZERO_REG != 0) && (bus.wa0 == '0));
  assign w1_ok = commit_en && bus.we1 && !((ZERO_REG != 0) && (bus.wa1 == '0));

  // Storage carries no reset so it can map onto RAM-style resources.
  // Port 1 is written last, so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem[idx] <= '0;
    end else begin
      if (w0_ok) mem[bus.wa0] <= bus.wd0;
      if (w1_ok) mem[bus.wa1] <= bus.wd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) conflict_q <= 1'b0;
    else      conflict_q <= w0_ok && w1_ok && (bus.wa0 == bus.wa1);
  end

  assign bus.ready       = ready;
  assign bus.wr_conflict = conflict_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   rk;
    logic [XLEN-1:0] dk;

    assign rk = bus.ra[k*AW +: AW];

    always_comb begin
      if (!ready)                                      dk = '0;
      else if ((ZERO_REG != 0) && (rk == '0))          dk = '0;
      else if ((BYPASS != 0) && w1_ok && (bus.wa1 == rk)) dk = bus.wd1;
      else if ((BYPASS != 0) && w0_ok && (bus.wa0 == rk)) dk = bus.wd0;
      else                                             dk = mem[rk];
    end

    assign bus.rd[k*XLEN +: XLEN] = dk;
  end
endmodule
